// File: rtl/if_id_queue_pkg.sv
// Shared defines for the IF/ID instruction queue: reset level, bus widths,
// the canonical zero word and the default queue depth.
package if_id_queue_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam int          InstAddrBusW = 32;
    localparam int          InstBusW     = 32;
    localparam int          ExcBusW      = 32;
    localparam int          DefaultDepth = 4;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: one-cycle latency FIFO of {pc, inst, excepttype},
// with flush and a NOP bubble (all-zero head) whenever it is empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH  = DefaultDepth,
    parameter int ADDR_W = InstAddrBusW,
    parameter int INST_W = InstBusW,
    parameter int EXC_W  = ExcBusW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [INST_W-1:0]        if_inst,
    input  logic [EXC_W-1:0]         if_excepttype,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [EXC_W-1:0]         id_excepttype,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [EXC_W-1:0]  exc_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Full/empty come from the occupancy count, so pointer equality is never ambiguous.
    assign if_ready = (count_q < CNT_W'(DEPTH));
    assign id_valid = (count_q != '0);
    assign push     = if_valid && if_ready && !flush;
    assign pop      = id_valid && id_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; stale slots are never visible
    // because the outputs are gated by occupancy, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (push && rst != RstEnable) begin
            pc_mem[wr_ptr_q]   <= if_pc;
            inst_mem[wr_ptr_q] <= if_inst;
            exc_mem[wr_ptr_q]  <= if_excepttype;
        end
    end

    assign id_pc         = id_valid ? pc_mem[rd_ptr_q]   : ADDR_W'(ZeroWord);
    assign id_inst       = id_valid ? inst_mem[rd_ptr_q] : INST_W'(ZeroWord);
    assign id_excepttype = id_valid ? exc_mem[rd_ptr_q]  : EXC_W'(ZeroWord);
    assign count         = count_q;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue at DEPTH=4, 32-bit buses.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_ready;
    logic        if_ready, id_valid;
    logic [31:0] if_pc, if_inst, if_excepttype;
    logic [31:0] id_pc, id_inst, id_excepttype;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    if_id_queue dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_excepttype (if_excepttype),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_excepttype (id_excepttype),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exc);
        if_valid      = v;
        if_pc         = pc;
        if_inst       = inst;
        if_excepttype = exc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        check("rst_count",    64'(count),    64'd0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_if_ready", 64'(if_ready), 64'd1);
        check("rst_id_pc",    64'(id_pc),    64'h0);

        // Single push into an empty queue is visible one edge later.
        offer(1'b1, 32'h100, 32'h2401_0001, 32'h0);
        step();
        check("p1_id_valid", 64'(id_valid), 64'd1);
        check("p1_id_pc",    64'(id_pc),    64'h100);
        check("p1_id_inst",  64'(id_inst),  64'h2401_0001);
        check("p1_count",    64'(count),    64'd1);

        // Fill to DEPTH; 0x108 carries a non-zero exception code.
        offer(1'b1, 32'h104, 32'h1000_0104, 32'h0);
        step();
        offer(1'b1, 32'h108, 32'h1000_0108, 32'hDEAD_0001);
        step();
        offer(1'b1, 32'h10C, 32'h1000_010C, 32'h0);
        step();
        check("full_count",    64'(count),    64'd4);
        check("full_if_ready", 64'(if_ready), 64'd0);

        offer(1'b1, 32'h200, 32'h2000_0000, 32'h0);
        step();
        check("drop_count", 64'(count), 64'd4);
        check("drop_head",  64'(id_pc), 64'h100);

        // Pop while full with if_valid high: no pass-through, count drops to 3.
        id_ready = 1'b1;
        step();
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        check("full_pop_count", 64'(count), 64'd3);
        check("pop0_pc",        64'(id_pc), 64'h104);
        step();
        check("pop1_pc",  64'(id_pc),         64'h108);
        check("pop1_exc", 64'(id_excepttype), 64'hDEAD_0001);
        step();
        check("pop2_pc",   64'(id_pc),   64'h10C);
        check("pop2_inst", 64'(id_inst), 64'h1000_010C);
        step();
        check("drain_count", 64'(count),    64'd0);
        check("drain_valid", 64'(id_valid), 64'd0);
        check("drain_pc",    64'(id_pc),    64'h0);

        // Popping an empty queue is ignored.
        for (int i = 0; i < 3; i++) begin
            step();
            check("empty_count", 64'(count),    64'd0);
            check("empty_valid", 64'(id_valid), 64'd0);
            check("empty_inst",  64'(id_inst),  64'h0);
            check("empty_exc",   64'(id_excepttype), 64'h0);
        end

        // Count=2, then simultaneous push/pop across pointer wrap.
        id_ready = 1'b0;
        offer(1'b1, 32'h300, 32'h3000_0300, 32'h0);
        step();
        offer(1'b1, 32'h304, 32'h3000_0304, 32'h0);
        step();
        check("sp_pre_count", 64'(count), 64'd2);
        id_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("sp_head", 64'(id_pc), 64'(32'h300 + 32'(4 * k)));
            offer(1'b1, 32'h308 + 32'(4 * k), 32'h3000_0308 + 32'(4 * k), 32'h0);
            step();
            check("sp_count", 64'(count), 64'd2);
        end
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        check("sp_tail0_pc",   64'(id_pc),   64'h328);
        check("sp_tail0_inst", 64'(id_inst), 64'h3000_0328);
        step();
        check("sp_tail1_pc", 64'(id_pc), 64'h32C);
        step();
        check("sp_end_count", 64'(count), 64'd0);

        // Flush overrides a simultaneous push and pop.
        id_ready = 1'b0;
        offer(1'b1, 32'h400, 32'h4000_0400, 32'h0);
        step();
        offer(1'b1, 32'h404, 32'h4000_0404, 32'h0);
        step();
        offer(1'b1, 32'h408, 32'h4000_0408, 32'h1);
        step();
        check("fl_pre_count", 64'(count), 64'd3);
        flush = 1'b1; id_ready = 1'b1;
        offer(1'b1, 32'h40C, 32'h4000_040C, 32'h0);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        check("fl_count", 64'(count),         64'd0);
        check("fl_valid", 64'(id_valid),      64'd0);
        check("fl_pc",    64'(id_pc),         64'h0);
        check("fl_exc",   64'(id_excepttype), 64'h0);
        step();
        check("fl_discard_count", 64'(count), 64'd0);

        // Reset mid-stream discards entries and wins over a push.
        id_ready = 1'b0;
        offer(1'b1, 32'h500, 32'h5000_0500, 32'h0);
        step();
        offer(1'b1, 32'h504, 32'h5000_0504, 32'h0);
        step();
        check("rs_pre_count", 64'(count), 64'd2);
        rst = 1'b1;
        offer(1'b1, 32'h508, 32'h5000_0508, 32'h0);
        step();
        check("rs_count",    64'(count),    64'd0);
        check("rs_if_ready", 64'(if_ready), 64'd1);
        check("rs_id_valid", 64'(id_valid), 64'd0);
        rst = 1'b0;
        offer(1'b1, 32'h600, 32'h6000_0600, 32'h0);
        step();
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        check("rs_push_count", 64'(count), 64'd1);
        check("rs_push_pc",    64'(id_pc), 64'h600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entry count; power of two, 2..16.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning PC width.
REQ-003 SHALL have parameter INST_W, default 32, meaning instruction width.
REQ-004 SHALL have parameter EXC_W, default 32, meaning exception-type width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port flush  input  1  exception/branch flush; discards all entries.
REQ-008 SHALL have port if_valid  input  1  IF offers an entry this cycle.
REQ-009 SHALL have port if_ready  output  1  queue can accept an entry (count < DEPTH).
REQ-010 SHALL have port if_pc / if_inst / if_excepttype  input  ADDR_W / INST_W / EXC_W  fetched entry.
REQ-011 SHALL have port id_ready  input  1  ID consumes the head this cycle (ID not stalled).
REQ-012 SHALL have port id_valid  output  1  head entry present.
REQ-013 SHALL have port id_pc / id_inst / id_excepttype  output  ADDR_W / INST_W / EXC_W  head entry; all zero when id_valid=0.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push SHALL occur on a rising edge when if_valid=1 and if_ready=1 and flush=0; entry written at the tail.
REQ-016 Pop SHALL occur on a rising edge when id_valid=1 and id_ready=1 and flush=0; head advances.
REQ-017 if_ready SHALL be combinational: 1 iff count < DEPTH; it does not depend on id_ready (no pass-through when full).
REQ-018 Latency SHALL be one cycle: an entry pushed at edge N is visible on id_* at edge N+1, including when the queue was empty.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-020 Pop while empty SHALL be ignored; push while full SHALL be ignored (if_ready=0).
REQ-021 When empty, id_valid=0 and id_pc, id_inst, id_excepttype SHALL be zero, so ID sees a NOP bubble.
REQ-022 flush=1 SHALL, at the next edge, set count=0 and both pointers to 0; flush SHALL override any simultaneous push or pop.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be decided from count, never from pointer equality.
REQ-024 count SHALL never exceed DEPTH and never underflow.
REQ-025 Storage contents need no clearing; only valid occupancy defines the outputs.

Reset
REQ-026 rst=1 SHALL, at the next edge, set count=0 and pointers=0, giving id_valid=0, id_*=0 and if_ready=1.
REQ-027 rst SHALL take priority over flush, push and pop; reset asserted mid-stream SHALL discard all entries.
REQ-028 After rst deasserts, the first push SHALL be accepted in the same cycle.

Structure
REQ-029 The shared defines file SHALL supply ZeroWord, RstEnable, InstAddrBus/InstBus widths and the default DEPTH; no module-local literals for these.
REQ-030 The block SHALL be a single module with an inline storage array and counters; no sub-module.

Verification
REQ-031 Reset then push pc=0x100, inst=0x24010001, exc=0 with id_ready=0 -> next cycle id_valid=1, id_pc=0x100, count=1.
REQ-032 DEPTH=4, push 4 entries with id_ready=0 -> count=4, if_ready=0; a 5th push is dropped; pops return pc 0x100, 0x104, 0x108, 0x10C in order.
REQ-033 count=2, simultaneous push and pop for 10 cycles crossing pointer wrap -> count stays 2, order preserved, no loss.
REQ-034 count=3 with flush=1, if_valid=1, id_ready=1 on the same edge -> count=0, id_valid=0, id_*=0, pushed entry discarded.
REQ-035 Empty queue with id_ready=1 for 3 cycles -> id_valid=0, outputs zero, count stays 0.
REQ-036 rst=1 while count=2 and flush=0 -> next cycle count=0, if_ready=1; push the following cycle is accepted.
